uart_tx_periph: RTL and testbench

- Memory-mapped UART transmitter on the SOPC data bus, alongside data_ram.
- Sits downstream of the CPU ram_* port (ce/we/addr/sel/data) and drives one int_i bit back into the core.
- Bytes written by software go into a TX FIFO, then are serialized 8N1 on tx_o at a programmable baud divisor.

---
 rtl/uart_tx_periph.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with a TX FIFO.
// Register map on addr[3:2]: 0 TXDATA, 1 STATUS, 2 DIVISOR, 3 CTRL.
// Optional feature: define UART_PARITY_EN to add a parity bit (11-bit frame,
// CTRL[4] selects odd parity). Without it the frame is 10 bits and CTRL[4]
// is neither stored nor read back.
module uart_tx_periph #(
  parameter int          FIFO_AW   = 3,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        int_o
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t r_state, w_next_state;

  logic [7:0]         r_mem [0:DEPTH-1];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_ovf;
  logic [15:0]        r_div;
  logic               r_tx_en, r_int_en;
  logic [7:0]         r_shift;
  logic [2:0]         r_bit_idx;
  logic [15:0]        r_baud;
  logic               r_tx, r_int;
`ifdef UART_PARITY_EN
  logic               r_par_odd;
  logic               w_parity;
`endif

  logic        w_wr, w_push, w_push_ok, w_pop, w_full, w_empty, w_busy;
  logic        w_bit_end, w_tx_bit, w_ctrl_wr;
  logic [1:0]  w_reg;
  logic [15:0] w_div_eff;
  logic [31:0] w_status, w_ctrl_rd, w_rdata;
  logic        w_unused;

  assign w_reg     = addr[3:2];
  assign w_wr      = ce & we & (sel != 4'b0000);
  assign w_push    = w_wr & (w_reg == 2'd0);
  assign w_ctrl_wr = w_wr & (w_reg == 2'd3);
  assign w_full    = (r_count == CNT_FULL);
  assign w_empty   = (r_count == {(FIFO_AW+1){1'b0}});
  assign w_busy    = (r_state != S_IDLE);
  // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
  assign w_push_ok = w_push & (~w_full | w_pop);
  // A divisor of zero behaves as one so the line never stalls.
  assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_bit_end = (r_baud == 16'd0);
  assign w_unused  = &{1'b0, addr[31:4], addr[1:0], data_i[31:16]};
`ifdef UART_PARITY_EN
  assign w_parity  = (^r_shift) ^ r_par_odd;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // FSM next-state, FIFO pop request and serial bit selection.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_tx_bit     = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_tx_bit = 1'b1;
        if (r_tx_en && !w_empty) begin
          w_pop        = 1'b1;
          w_next_state = S_START;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_START: begin
        w_tx_bit = 1'b0;
        if (w_bit_end) w_next_state = S_DATA;
        else           w_next_state = S_START;
      end
      S_DATA: begin
        w_tx_bit = r_shift[r_bit_idx];
        if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_PARITY_EN
          w_next_state = S_PARITY;
`else
          w_next_state = S_STOP;
`endif
        end else begin
          w_next_state = S_DATA;
        end
      end
      S_PARITY: begin
`ifdef UART_PARITY_EN
        w_tx_bit = w_parity;
        if (w_bit_end) w_next_state = S_STOP;
        else           w_next_state = S_PARITY;
`else
        w_tx_bit     = 1'b1;
        w_next_state = S_IDLE;
`endif
      end
      S_STOP: begin
        w_tx_bit = 1'b1;
        if (w_bit_end) begin
          // Back-to-back frames: pop straight into the next start bit.
          if (r_tx_en && !w_empty) begin
            w_pop        = 1'b1;
            w_next_state = S_START;
          end else begin
            w_next_state = S_IDLE;
          end
        end else begin
          w_next_state = S_STOP;
        end
      end
      default: begin
        w_tx_bit     = 1'b1;
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Shift register load, bit index and baud counter (reloads at each bit boundary).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= 8'h00;
      r_bit_idx <= 3'd0;
      r_baud    <= 16'd0;
    end else begin
      if (w_pop) r_shift <= r_mem[r_rptr];
      if (r_state == S_IDLE) begin
        r_baud    <= w_div_eff - 16'd1;
        r_bit_idx <= 3'd0;
      end else if (w_bit_end) begin
        r_baud <= w_div_eff - 16'd1;
        if (r_state == S_DATA) r_bit_idx <= r_bit_idx + 3'd1;
      end else begin
        r_baud <= r_baud - 16'd1;
      end
    end
  end

  // TX FIFO storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
      r_wptr  <= {FIFO_AW{1'b0}};
      r_rptr  <= {FIFO_AW{1'b0}};
      r_count <= {(FIFO_AW+1){1'b0}};
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= data_i[7:0];
        r_wptr        <= r_wptr + PTR_ONE;
      end
      if (w_pop) r_rptr <= r_rptr + PTR_ONE;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop)  r_ovf <= 1'b1;
      else if (w_ctrl_wr && data_i[3]) r_ovf <= 1'b0;
    end
  end

  // DIVISOR and CTRL software registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div    <= DIV_RESET;
      r_tx_en  <= 1'b0;
      r_int_en <= 1'b0;
`ifdef UART_PARITY_EN
      r_par_odd <= 1'b0;
`endif
    end else begin
      if (w_wr && (w_reg == 2'd2)) r_div <= data_i[15:0];
      if (w_ctrl_wr) begin
        r_tx_en  <= data_i[0];
        r_int_en <= data_i[1];
`ifdef UART_PARITY_EN
        r_par_odd <= data_i[4];
`endif
      end
    end
  end

  // Registered serial line and interrupt outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx  <= 1'b1;
      r_int <= 1'b0;
    end else begin
      r_tx  <= w_tx_bit;
      r_int <= r_int_en & w_empty & ~w_busy;
    end
  end

  assign tx_o  = r_tx;
  assign int_o = r_int;

  // STATUS and CTRL read images.
  always_comb begin
    w_status = 32'h0;
    w_status[0] = w_busy;
    w_status[1] = w_full;
    w_status[2] = w_empty;
    w_status[3] = r_ovf;
    w_status[8 +: FIFO_AW+1] = r_count;
    w_ctrl_rd = 32'h0;
    w_ctrl_rd[0] = r_tx_en;
    w_ctrl_rd[1] = r_int_en;
`ifdef UART_PARITY_EN
    w_ctrl_rd[4] = r_par_odd;
`endif
  end

  // Combinational read mux; zero unless a read is selected.
  always_comb begin
    w_rdata = 32'h0;
    if (ce && !we) begin
      case (w_reg)
        2'd0:    w_rdata = 32'h0;
        2'd1:    w_rdata = w_status;
        2'd2:    w_rdata = {16'h0, r_div};
        2'd3:    w_rdata = w_ctrl_rd;
        default: w_rdata = 32'h0;
      endcase
    end else begin
      w_rdata = 32'h0;
    end
  end

  assign data_o = w_rdata;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboard bench for uart_tx_periph: stimulus pushes expected bytes into a
// queue; a line monitor decodes frames on tx_o and pops/compares them.
module tb_uart_tx_periph;

`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        clk, rst, ce, we, tx_o, int_o;
  logic [31:0] addr, data_i, data_o;
  logic [3:0]  sel;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   bit_p = 434;
  logic par_odd = 1'b0;
  logic [7:0] exp_q [$];
  int         start_q [$];

  uart_tx_periph #(.FIFO_AW(3), .DIV_RESET(16'd434)) dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .tx_o(tx_o), .int_o(int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    ce = 1'b1; we = 1'b1; sel = 4'hF; addr = {28'h0, a, 2'b00}; data_i = d;
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0; sel = 4'h0; addr = 32'h0; data_i = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    ce = 1'b1; we = 1'b0; sel = 4'hF; addr = {28'h0, a, 2'b00};
    #1 d = data_o;
    ce = 1'b0; sel = 4'h0; addr = 32'h0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d frames pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Line monitor: every bit must hold its level for bit_p cycles.
  initial begin : monitor
    logic [7:0] got;
    logic       bitval, exp_par;
    bit         frame_ok, par_ok, aborted;
    int         p;
    forever begin
      @(negedge clk);
      if (rst && tx_o == 1'b0) begin
        frame_ok = 1'b1; par_ok = 1'b1; aborted = 1'b0; got = 8'h00;
        bitval = 1'b0; p = bit_p;
        start_q.push_back(cyc);
        for (int b = 0; b < FRAME_BITS && !aborted; b++) begin
          for (int s = 0; s < p && !aborted; s++) begin
            if (!(b == 0 && s == 0)) @(negedge clk);
            if (!rst) aborted = 1'b1;
            else if (s == 0) bitval = tx_o;
            else if (tx_o !== bitval) frame_ok = 1'b0;
          end
          if (!aborted) begin
            if (b == 0 && bitval !== 1'b0) frame_ok = 1'b0;
            if (b >= 1 && b <= 8) got[b-1] = bitval;
            if (b == FRAME_BITS - 1 && bitval !== 1'b1) frame_ok = 1'b0;
`ifdef UART_PARITY_EN
            if (b == 9) begin
              exp_par = (exp_q.size() != 0) ? ((^exp_q[0]) ^ par_odd) : 1'b0;
              if (bitval !== exp_par) par_ok = 1'b0;
            end
`endif
          end
        end
        if (aborted) begin
          void'(start_q.pop_back());
        end else if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_frame: got %02h expected no frame", got);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          n_vec++;
          if (got !== e || !frame_ok || !par_ok) begin
            n_err++;
            $display("FAIL frame: got %02h (framing_ok=%0d parity_ok=%0d) expected %02h",
                     got, frame_ok, par_ok, e);
          end
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] rd;
    rst = 1'b1; ce = 1'b0; we = 1'b0; sel = 4'h0; addr = 32'h0; data_i = 32'h0;
    #1 rst = 1'b0;
    #1;
    // Reset state.
    chk("rst_tx", {31'h0, tx_o}, 32'h1);
    chk("rst_int", {31'h0, int_o}, 32'h0);
    bus_read(2'd1, rd); chk("rst_status", rd, 32'h0000_0004);
    bus_read(2'd2, rd); chk("rst_divisor", rd, 32'd434);
    bus_read(2'd3, rd); chk("rst_ctrl", rd, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Single frame 0xA5 with period 4, latency to start bit.
    bus_write(2'd2, 32'd4);
    bus_write(2'd3, 32'h1);
    bit_p = 4;
    exp_q.push_back(8'hA5);
    bus_write(2'd0, 32'hA5);
    @(posedge clk); #1; chk("lat_edge1_high", {31'h0, tx_o}, 32'h1);
    @(posedge clk); #1; chk("lat_edge2_low", {31'h0, tx_o}, 32'h0);
    wait_drain();
    bus_read(2'd1, rd); chk("idle_after_a5", rd, 32'h0000_0004);

    // Fill beyond depth with TX disabled, then drain back-to-back.
    bus_write(2'd2, 32'd2);
    bus_write(2'd3, 32'h0);
    bit_p = 2;
    start_q.delete();
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i));
      bus_write(2'd0, 32'(i));
    end
    bus_read(2'd1, rd); chk("status_overflow", rd, 32'h0000_080A);
    // Enable + clear overflow, then push on the exact pop edge while full.
    bus_write(2'd3, 32'h0B);
    exp_q.push_back(8'h0A);
    bus_write(2'd0, 32'h0A);
    bus_read(2'd1, rd); chk("status_push_at_pop", rd, 32'h0000_0803);
    bus_read(2'd3, rd); chk("ctrl_readback", rd, 32'h3);
    wait_drain();
    chk("frame_count", 32'(start_q.size()), 32'd9);
    for (int i = 1; i < start_q.size(); i++)
      chk("b2b_gap", 32'(start_q[i] - start_q[i-1]), 32'(FRAME_BITS * 2));

    // Interrupt: high when idle and empty, low while busy, rises one cycle after IDLE.
    bus_write(2'd3, 32'h13);
    par_odd = 1'b1;
    chk("int_idle", {31'h0, int_o}, 32'h1);
    bus_read(2'd3, rd);
`ifdef UART_PARITY_EN
    chk("ctrl_par_rb", rd, 32'h13);
`else
    chk("ctrl_par_rb", rd, 32'h03);
`endif
    exp_q.push_back(8'h5A);
    bus_write(2'd0, 32'h5A);
    @(posedge clk); #1; chk("int_drop", {31'h0, int_o}, 32'h0);
    repeat (FRAME_BITS * 2) @(posedge clk);
    #1 chk("int_at_idle_edge", {31'h0, int_o}, 32'h0);
    @(posedge clk); #1; chk("int_rise", {31'h0, int_o}, 32'h1);
    wait_drain();

    // Reset mid data bit: line returns high at once, FIFO empties.
    bus_write(2'd2, 32'd4);
    bus_write(2'd3, 32'h1);
    bit_p = 4; par_odd = 1'b0;
    bus_write(2'd0, 32'h3C);
    bus_write(2'd0, 32'h99);
    repeat (11) @(posedge clk);
    #1 chk("tx_mid_bit1", {31'h0, tx_o}, 32'h0);
    rst = 1'b0;
    #1 chk("tx_async_rst", {31'h0, tx_o}, 32'h1);
    bus_read(2'd1, rd); chk("status_after_rst", rd, 32'h0000_0004);
    bus_read(2'd2, rd); chk("div_after_rst", rd, 32'd434);
    chk("int_after_rst", {31'h0, int_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    bus_write(2'd2, 32'd4);
    bus_write(2'd3, 32'h1);
    exp_q.push_back(8'h07);
    bus_write(2'd0, 32'h07);
    wait_drain();
    bus_read(2'd1, rd); chk("final_status", rd, 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
